mem_arbiter: RTL and testbench

//  Shares the single physical-memory line port between the I-cache miss path and D-cache

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the pmem line-port arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 128;

  typedef logic [LINE_W_DEF-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    ARB_SRC_I,
    ARB_SRC_D
  } arb_src_t;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } arb_op_t;

  // Serving state for a given winner.
  function automatic arb_state_t serve_state(input arb_src_t src);
    return (src == ARB_SRC_D) ? ARB_SERVE_D : ARB_SERVE_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and pmem-side signal bundle for mem_arbiter.
// slave  : the arbiter's view.
// master : the environment's view (both caches plus pmem).
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  // I-cache miss path
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache miss / writeback path
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // physical memory line port
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              busy;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single pmem line port between the I-cache and D-cache.
// One requester is granted at a time; its address/data/op are latched at
// grant and held until pmem_resp, after which a one-cycle DONE gap lets the
// requester drop its level before the next arbitration.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter bit RR     = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state, state_nx;
  arb_src_t          last_grant;
  arb_src_t          winner;
  arb_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              req_i, req_d, grant;
  logic              serving;

  // Arbitration: D wins when alone, when fixed priority, or when I went last.
  always_comb begin
    req_i  = bus.i_read;
    req_d  = bus.d_read | bus.d_write;
    winner = ARB_SRC_I;
    grant  = 1'b0;
    if (req_d && (!req_i || !RR || last_grant == ARB_SRC_I)) begin
      winner = ARB_SRC_D;
      grant  = 1'b1;
    end else if (req_i) begin
      winner = ARB_SRC_I;
      grant  = 1'b1;
    end
  end

  // Next state and all outputs. Responses are gated by reset so a pmem_resp
  // arriving together with reset is dropped; strobes follow registered state.
  always_comb begin
    serving  = (state == ARB_SERVE_I) || (state == ARB_SERVE_D);
    state_nx = state;
    case (state)
      ARB_IDLE:    if (grant) state_nx = serve_state(winner);
      ARB_SERVE_I,
      ARB_SERVE_D: if (bus.pmem_resp) state_nx = ARB_DONE;
      ARB_DONE:    state_nx = ARB_IDLE;
      default:     state_nx = ARB_IDLE;
    endcase

    bus.pmem_read    = serving && (op_q == ARB_OP_READ);
    bus.pmem_write   = serving && (op_q == ARB_OP_WRITE);
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_resp       = reset && bus.pmem_resp && (state == ARB_SERVE_I);
    bus.d_resp       = reset && bus.pmem_resp && (state == ARB_SERVE_D);
    bus.i_rdata      = bus.pmem_rdata;
    bus.d_rdata      = bus.pmem_rdata;
    bus.busy         = (state != ARB_IDLE);
  end

  // FSM register plus grant-time latches; requester inputs are ignored
  // once a transaction is under way. d_write beats d_read so a writeback
  // always goes out ahead of the refill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_SRC_I;
      op_q       <= ARB_OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && grant) begin
        last_grant <= winner;
        if (winner == ARB_SRC_D) begin
          addr_q  <= bus.d_address;
          wdata_q <= bus.d_wdata;
          op_q    <= bus.d_write ? ARB_OP_WRITE : ARB_OP_READ;
        end else begin
          addr_q  <= bus.i_address;
          op_q    <= ARB_OP_READ;
        end
      end
    end
  end

  // Port-level invariants.
  a_one_strobe: assert property (@(posedge clk) !(bus.pmem_read && bus.pmem_write));
  a_one_resp:   assert property (@(posedge clk) !(bus.i_resp && bus.d_resp));
  // Fires when a combined read+write request is granted and resolved to a write.
  c_rw_both:    cover property (@(posedge clk)
                  reset && state == ARB_IDLE && grant && winner == ARB_SRC_D &&
                  bus.d_read && bus.d_write);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dut0 runs round-robin, dut1 fixed D priority.
// A transaction-level model (owner / gap / last winner) predicts every
// output each cycle; directed scenarios add literal expectations.
`define ARB_BIND(B, K) \
  assign B.i_read     = i_read[K]; \
  assign B.i_address  = i_addr[K]; \
  assign B.d_read     = d_read[K]; \
  assign B.d_write    = d_write[K]; \
  assign B.d_address  = d_addr[K]; \
  assign B.d_wdata    = d_wdata[K]; \
  assign B.pmem_rdata = pmem_rdata[K]; \
  assign B.pmem_resp  = pmem_resp[K]; \
  assign o_i_resp[K]  = B.i_resp; \
  assign o_d_resp[K]  = B.d_resp; \
  assign o_i_rdata[K] = B.i_rdata; \
  assign o_d_rdata[K] = B.d_rdata; \
  assign o_pread[K]   = B.pmem_read; \
  assign o_pwrite[K]  = B.pmem_write; \
  assign o_paddr[K]   = B.pmem_address; \
  assign o_pwdata[K]  = B.pmem_wdata; \
  assign o_busy[K]    = B.busy;

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst_n, i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr [2];
  logic [AW-1:0] d_addr [2];
  logic [LW-1:0] d_wdata [2];
  logic [LW-1:0] pmem_rdata [2];

  logic [1:0]    o_i_resp, o_d_resp, o_pread, o_pwrite, o_busy;
  logic [LW-1:0] o_i_rdata [2];
  logic [LW-1:0] o_d_rdata [2];
  logic [LW-1:0] o_pwdata [2];
  logic [AW-1:0] o_paddr [2];

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus0 ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

  `ARB_BIND(bus0, 0)
  `ARB_BIND(bus1, 1)

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR(1'b1)) dut0 (.clk(clk), .reset(rst_n[0]), .bus(bus0));
  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR(1'b0)) dut1 (.clk(clk), .reset(rst_n[1]), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chkb(input string nm, input int k, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %b expected %b", nm, k, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input int k, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 I, 2 D. gap: the single dead cycle after a completion.
  logic [1:0]    m_owner [2];
  bit            m_gap   [2];
  bit            m_lastd [2];
  bit            m_wr    [2];
  logic [AW-1:0] m_addr  [2];
  logic [LW-1:0] m_wdata [2];

  // Advance the model on each clock from the inputs presented that cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit want_d, want_i, tie_to_d;
      want_d   = d_read[k] | d_write[k];
      want_i   = i_read[k];
      tie_to_d = (k == 1) || !m_lastd[k];
      if (!rst_n[k]) begin
        m_owner[k] <= 2'd0; m_gap[k] <= 1'b0; m_lastd[k] <= 1'b0;
        m_wr[k] <= 1'b0; m_addr[k] <= '0; m_wdata[k] <= '0;
      end else if (m_owner[k] != 2'd0) begin
        if (pmem_resp[k]) begin m_owner[k] <= 2'd0; m_gap[k] <= 1'b1; end
      end else if (m_gap[k]) begin
        m_gap[k] <= 1'b0;
      end else if (want_d && (!want_i || tie_to_d)) begin
        m_owner[k] <= 2'd2; m_lastd[k] <= 1'b1; m_addr[k] <= d_addr[k];
        m_wdata[k] <= d_wdata[k]; m_wr[k] <= d_write[k];
      end else if (want_i) begin
        m_owner[k] <= 2'd1; m_lastd[k] <= 1'b0; m_addr[k] <= i_addr[k]; m_wr[k] <= 1'b0;
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit srv;
        srv = (m_owner[k] != 2'd0);
        chkb("busy",       k, o_busy[k],   srv || m_gap[k]);
        chkb("pmem_read",  k, o_pread[k],  srv && !m_wr[k]);
        chkb("pmem_write", k, o_pwrite[k], srv && m_wr[k]);
        chkb("i_resp",     k, o_i_resp[k], rst_n[k] && pmem_resp[k] && m_owner[k] == 2'd1);
        chkb("d_resp",     k, o_d_resp[k], rst_n[k] && pmem_resp[k] && m_owner[k] == 2'd2);
        if (srv) chkv("pmem_address", k, LW'(o_paddr[k]), LW'(m_addr[k]));
        if (srv && m_wr[k]) chkv("pmem_wdata", k, o_pwdata[k], m_wdata[k]);
        if (o_i_resp[k]) chkv("i_rdata", k, o_i_rdata[k], pmem_rdata[k]);
        if (o_d_resp[k]) chkv("d_rdata", k, o_d_rdata[k], pmem_rdata[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  bit seen_i [2];
  bit seen_d [2];

  initial begin
    rst_n = 2'b00; i_read = '0; d_read = '0; d_write = '0; pmem_resp = '0;
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; pmem_rdata[k] = '0;
      seen_i[k] = 1'b0; seen_d[k] = 1'b0;
    end
    cyc(); cyc();
    rst_n = 2'b11; chk_en = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chkb("rst busy", k, o_busy[k], 1'b0);
      chkb("rst pmem_read", k, o_pread[k], 1'b0);
      chkb("rst pmem_write", k, o_pwrite[k], 1'b0);
      chkv("rst pmem_address", k, LW'(o_paddr[k]), '0);
      chkv("rst pmem_wdata", k, o_pwdata[k], '0);
    end

    // T1: lone I miss, pmem answers in the 4th strobe cycle
    i_read[0] = 1'b1; i_addr[0] = 16'h1230;
    cyc();
    i_addr[0] = 16'hFFF0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) begin pmem_resp[0] = 1'b1; pmem_rdata[0] = {16{8'hA5}}; end
      #1;
      chkb("t1 pmem_read", 0, o_pread[0], 1'b1);
      chkv("t1 pmem_address", 0, LW'(o_paddr[0]), LW'(16'h1230));
      chkb("t1 i_resp", 0, o_i_resp[0], s == 3);
      if (s < 3) cyc();
    end
    chkv("t1 i_rdata", 0, o_i_rdata[0], {16{8'hA5}});
    chkb("t1 d_resp", 0, o_d_resp[0], 1'b0);
    cyc(); pmem_resp[0] = 1'b0; i_read[0] = 1'b0; #1;
    chkb("t1 done busy", 0, o_busy[0], 1'b1);
    chkb("t1 done strobe", 0, o_pread[0], 1'b0);
    cyc(); #1;
    chkb("t1 idle busy", 0, o_busy[0], 1'b0);

    // T2a: tie after reset, round-robin -> D first, I strobes at M+3
    rst_n[0] = 1'b0; cyc(); rst_n[0] = 1'b1;
    i_read[0] = 1'b1; i_addr[0] = 16'h1000; d_read[0] = 1'b1; d_addr[0] = 16'h2000;
    cyc(); #1;
    chkv("t2 first grant", 0, LW'(o_paddr[0]), LW'(16'h2000));
    pmem_resp[0] = 1'b1; pmem_rdata[0] = {16{8'h3C}}; #1;
    chkb("t2 d_resp", 0, o_d_resp[0], 1'b1);
    chkb("t2 i_resp", 0, o_i_resp[0], 1'b0);
    chkv("t2 d_rdata", 0, o_d_rdata[0], {16{8'h3C}});
    cyc(); pmem_resp[0] = 1'b0; d_read[0] = 1'b0;
    cyc(); #1;
    chkb("t2 M+2 idle", 0, o_busy[0], 1'b0);
    cyc(); #1;
    chkb("t2 M+3 strobe", 0, o_pread[0], 1'b1);
    chkv("t2 second grant", 0, LW'(o_paddr[0]), LW'(16'h1000));
    pmem_resp[0] = 1'b1; #1;
    chkb("t2 i_resp", 0, o_i_resp[0], 1'b1);
    cyc(); pmem_resp[0] = 1'b0; i_read[0] = 1'b0;
    cyc();

    // T2b: fixed priority, D held continuously -> I starves until D drops
    i_read[1] = 1'b1; i_addr[1] = 16'h1110; d_read[1] = 1'b1; d_addr[1] = 16'h2220;
    for (int r = 0; r < 3; r++) begin
      cyc(); #1;
      chkv("t2b D wins", 1, LW'(o_paddr[1]), LW'(16'h2220));
      pmem_resp[1] = 1'b1; #1;
      chkb("t2b i_resp", 1, o_i_resp[1], 1'b0);
      cyc(); pmem_resp[1] = 1'b0;
      cyc();
    end
    d_read[1] = 1'b0;
    cyc(); #1;
    chkv("t2b I finally", 1, LW'(o_paddr[1]), LW'(16'h1110));
    pmem_resp[1] = 1'b1; #1;
    chkb("t2b i_resp", 1, o_i_resp[1], 1'b1);
    cyc(); pmem_resp[1] = 1'b0; i_read[1] = 1'b0;
    cyc();

    // T3: writeback, wdata/address latched at grant
    d_write[0] = 1'b1; d_addr[0] = 16'h8000; d_wdata[0] = 128'h1;
    cyc();
    d_wdata[0] = 128'hDEAD_BEEF; d_addr[0] = 16'h9990; #1;
    chkb("t3 pmem_write", 0, o_pwrite[0], 1'b1);
    chkb("t3 pmem_read", 0, o_pread[0], 1'b0);
    chkv("t3 pmem_wdata", 0, o_pwdata[0], 128'h1);
    chkv("t3 pmem_address", 0, LW'(o_paddr[0]), LW'(16'h8000));
    cyc(); #1;
    chkv("t3 wdata stable", 0, o_pwdata[0], 128'h1);
    pmem_resp[0] = 1'b1; #1;
    chkb("t3 d_resp", 0, o_d_resp[0], 1'b1);
    cyc(); pmem_resp[0] = 1'b0; d_write[0] = 1'b0;
    cyc();

    // T4: reset mid SERVE_I, late resp dropped
    i_read[0] = 1'b1; i_addr[0] = 16'h4440;
    cyc(); #1;
    chkb("t4 serving", 0, o_pread[0], 1'b1);
    rst_n[0] = 1'b0; i_read[0] = 1'b0; #1;
    chkb("t4 strobe holds", 0, o_pread[0], 1'b1);
    cyc(); rst_n[0] = 1'b1; pmem_resp[0] = 1'b1; #1;
    chkb("t4 strobe dropped", 0, o_pread[0], 1'b0);
    chkb("t4 no i_resp", 0, o_i_resp[0], 1'b0);
    chkb("t4 idle", 0, o_busy[0], 1'b0);
    cyc(); pmem_resp[0] = 1'b0;
    // reset coinciding with pmem_resp during a D write
    d_write[0] = 1'b1; d_addr[0] = 16'h5550; d_wdata[0] = 128'h7;
    cyc();
    rst_n[0] = 1'b0; pmem_resp[0] = 1'b1; d_write[0] = 1'b0; #1;
    chkb("t4 reset beats resp", 0, o_d_resp[0], 1'b0);
    cyc(); rst_n[0] = 1'b1; pmem_resp[0] = 1'b0; #1;
    chkb("t4b idle", 0, o_busy[0], 1'b0);
    // last grant back to I although D won last -> D wins the tie
    i_read[0] = 1'b1; i_addr[0] = 16'h6660; d_read[0] = 1'b1; d_addr[0] = 16'h7770;
    cyc(); #1;
    chkv("t4 last_grant=I", 0, LW'(o_paddr[0]), LW'(16'h7770));
    pmem_resp[0] = 1'b1;
    cyc(); pmem_resp[0] = 1'b0; d_read[0] = 1'b0;
    cyc(); cyc(); #1;
    chkv("t4 then I", 0, LW'(o_paddr[0]), LW'(16'h6660));
    pmem_resp[0] = 1'b1;
    cyc(); pmem_resp[0] = 1'b0; i_read[0] = 1'b0;
    cyc();

    // T5: stray responses, read+write resolves to write
    pmem_resp[0] = 1'b1; #1;
    chkb("t5 stray idle i", 0, o_i_resp[0], 1'b0);
    chkb("t5 stray idle d", 0, o_d_resp[0], 1'b0);
    cyc(); pmem_resp[0] = 1'b0; #1;
    chkb("t5 still idle", 0, o_busy[0], 1'b0);
    d_read[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 16'hA000; d_wdata[0] = 128'h55;
    cyc(); #1;
    chkb("t5 rw write", 0, o_pwrite[0], 1'b1);
    chkb("t5 rw no read", 0, o_pread[0], 1'b0);
    pmem_resp[0] = 1'b1; #1;
    chkb("t5 d_resp", 0, o_d_resp[0], 1'b1);
    cyc(); d_read[0] = 1'b0; d_write[0] = 1'b0; #1;
    chkb("t5 stray done d", 0, o_d_resp[0], 1'b0);
    chkb("t5 stray done i", 0, o_i_resp[0], 1'b0);
    cyc(); pmem_resp[0] = 1'b0; #1;
    chkb("t5 back idle", 0, o_busy[0], 1'b0);

    // Random phase: reactive requesters and pmem, occasional resets
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        rst_n[k] = ($urandom_range(99) != 0);
        if (i_read[k] && seen_i[k]) begin
          i_read[k] = 1'b0; seen_i[k] = 1'b0;
        end else if (!i_read[k]) begin
          if ($urandom_range(2) == 0) begin
            i_read[k] = 1'b1; i_addr[k] = AW'($urandom) & 16'hFFF0;
          end
        end else if ($urandom_range(7) == 0) begin
          i_addr[k] = AW'($urandom) & 16'hFFF0;
        end
        if ((d_read[k] | d_write[k]) && seen_d[k]) begin
          d_read[k] = 1'b0; d_write[k] = 1'b0; seen_d[k] = 1'b0;
        end else if (!(d_read[k] | d_write[k])) begin
          if ($urandom_range(2) == 0) begin
            int op;
            op = int'($urandom_range(9));
            d_read[k]  = (op < 5) || (op == 9);
            d_write[k] = (op >= 5);
            d_addr[k]  = AW'($urandom) & 16'hFFF0;
          end
        end
        d_wdata[k]    = {$urandom, $urandom, $urandom, $urandom};
        pmem_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
        if (o_pread[k] | o_pwrite[k]) pmem_resp[k] = ($urandom_range(2) == 0);
        else                          pmem_resp[k] = ($urandom_range(9) == 0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (o_i_resp[k]) seen_i[k] = 1'b1;
        if (o_d_resp[k]) seen_d[k] = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus process never completes.
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete (checks %0d, failures %0d)", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`undef ARB_BIND
